// File: rtl/regfile_pkg.sv
// Shared constants and write-port arbitration for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned ZERO_REG  = 0;

    // Arbitration works on write ports padded out to the widest supported configuration.
    localparam int unsigned MAX_NWR = 4;
    localparam int unsigned MAX_AW  = 16;

    typedef struct packed {
        logic       hit;
        logic [1:0] port;
    } wr_sel_t;

    // Highest-index enabled write port targeting addr; register 0 never matches.
    function automatic wr_sel_t win_port(input logic [MAX_NWR-1:0]        we,
                                         input logic [MAX_NWR*MAX_AW-1:0] addrs,
                                         input logic [MAX_AW-1:0]         addr);
        wr_sel_t sel;
        sel = '0;
        for (int unsigned j = 0; j < MAX_NWR; j++) begin
            if (we[j] && (addrs[j*MAX_AW +: MAX_AW] == addr) &&
                (addr != MAX_AW'(ZERO_REG))) begin
                sel.hit  = 1'b1;
                sel.port = 2'(j);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, a same-cycle set beats a clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 1,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    input  logic [NWR-1:0]    write_en,
    input  logic [NWR*AW-1:0] rd_addr,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0]          busy_q, busy_d;
    logic [MAX_NWR-1:0]        we_pad;
    logic [MAX_NWR*MAX_AW-1:0] addr_pad;

    always_comb begin
        we_pad   = '0;
        addr_pad = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            we_pad[j]                        = write_en[j];
            addr_pad[j*MAX_AW +: MAX_AW] = MAX_AW'(rd_addr[j*AW +: AW]);
        end
    end

    always_comb begin
        wr_sel_t sel;
        sel    = '0;
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            sel = win_port(we_pad, addr_pad, MAX_AW'(r));
            if (issue_en && (issue_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (sel.hit) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a busy scoreboard.
// Defining REGFILE_BYPASS_EN adds a same-cycle write-to-read bypass on every read port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR*AW-1:0]   rd_addr,
    input  logic [NWR*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      write_en,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr
);

    logic [XLEN-1:0]           mem_q [NREGS];
    logic [XLEN-1:0]           mem_d [NREGS];
    logic [NREGS-1:0]          busy;
    logic [MAX_NWR-1:0]        we_pad;
    logic [MAX_NWR*MAX_AW-1:0] addr_pad;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .write_en   (write_en),
        .rd_addr    (rd_addr),
        .busy       (busy)
    );

    always_comb begin
        we_pad   = '0;
        addr_pad = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            we_pad[j]                    = write_en[j];
            addr_pad[j*MAX_AW +: MAX_AW] = MAX_AW'(rd_addr[j*AW +: AW]);
        end
    end

    always_comb begin
        wr_sel_t sel;
        sel   = '0;
        mem_d = mem_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            sel = win_port(we_pad, addr_pad, MAX_AW'(r));
            if (sel.hit) begin
                mem_d[r] = rd_data[sel.port*XLEN +: XLEN];
            end
        end
        mem_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
        wr_sel_t       sel;
        sel = '0;
`endif
        ra      = '0;
        rs_data = '0;
        rs_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra                       = rs_addr[i*AW +: AW];
            rs_data[i*XLEN +: XLEN] = mem_q[ra];
            rs_busy[i]               = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // A bypassed value is ready now, unless the register is being re-issued.
            sel = win_port(we_pad, addr_pad, MAX_AW'(ra));
            if (sel.hit) begin
                rs_data[i*XLEN +: XLEN] = rd_data[sel.port*XLEN +: XLEN];
                rs_busy[i]               = issue_en && (issue_addr == ra);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read / 2 write ports) against an array-based model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR*AW-1:0]   rd_addr;
    logic [NWR*XLEN-1:0] rd_data;
    logic [NWR-1:0]      write_en;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;

    logic [XLEN-1:0] m_mem [NREGS];
    logic            m_busy [NREGS];
    int              total = 0;
    int              bad   = 0;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .write_en   (write_en),
        .issue_en   (issue_en),
        .issue_addr (issue_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] exp_data(input int i);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        a = rs_addr[i*AW +: AW];
        if (a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (write_en[j] && rd_addr[j*AW +: AW] == a) v = rd_data[j*XLEN +: XLEN];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int i);
        logic [AW-1:0] a;
        logic          b;
        a = rs_addr[i*AW +: AW];
        if (a == 0) return 1'b0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (write_en[j] && rd_addr[j*AW +: AW] == a) b = issue_en && (issue_addr == a);
`endif
        return b;
    endfunction

    // Apply the architectural effect of the current inputs at the next rising edge.
    task automatic tick();
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (write_en[j] && rd_addr[j*AW +: AW] != 0) begin
                    m_mem[rd_addr[j*AW +: AW]]  = rd_data[j*XLEN +: XLEN];
                    m_busy[rd_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = '0;
        issue_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rs_addr = {5'd5, 5'd1};
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0) begin
            bad++; $display("FAIL reset_data0 got=%h want=%h", rs_data[31:0], 32'h0);
        end
        total++;
        if (rs_data[63:32] !== 32'h0) begin
            bad++; $display("FAIL reset_data1 got=%h want=%h", rs_data[63:32], 32'h0);
        end
        total++;
        if (rs_busy !== 2'b00) begin
            bad++; $display("FAIL reset_busy got=%b want=%b", rs_busy, 2'b00);
        end
    endtask

    task automatic test_basic();
        write_en = 2'b01; rd_addr[4:0] = 5'd1; rd_data[31:0] = 32'h1;
        tick();
        rd_addr[4:0] = 5'd5; rd_data[31:0] = 32'hFFF;
        tick();
        idle();
        rs_addr = {5'd5, 5'd1};
        #1;
        total++;
        if (rs_data[31:0] !== 32'h1) begin
            bad++; $display("FAIL basic_x1 got=%h want=%h", rs_data[31:0], 32'h1);
        end
        total++;
        if (rs_data[63:32] !== 32'hFFF) begin
            bad++; $display("FAIL basic_x5 got=%h want=%h", rs_data[63:32], 32'hFFF);
        end
        rs_addr[4:0] = 5'd6;
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0) begin
            bad++; $display("FAIL basic_x6 got=%h want=%h", rs_data[31:0], 32'h0);
        end
    endtask

    task automatic test_zero();
        write_en = 2'b01; rd_addr[4:0] = 5'd0; rd_data[31:0] = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        idle();
        rs_addr[4:0] = 5'd0;
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0) begin
            bad++; $display("FAIL zero_data got=%h want=%h", rs_data[31:0], 32'h0);
        end
        total++;
        if (rs_busy[0] !== 1'b0) begin
            bad++; $display("FAIL zero_busy got=%b want=%b", rs_busy[0], 1'b0);
        end
    endtask

    task automatic test_conflict();
        write_en = 2'b11; rd_addr = {5'd3, 5'd3}; rd_data = {32'h5555, 32'hAAAA};
        tick();
        idle();
        rs_addr[4:0] = 5'd3;
        #1;
        total++;
        if (rs_data[31:0] !== 32'h5555) begin
            bad++; $display("FAIL conflict_x3 got=%h want=%h", rs_data[31:0], 32'h5555);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        rs_addr[4:0] = 5'd7;
        #1;
        total++;
        if (rs_busy[0] !== 1'b1) begin
            bad++; $display("FAIL sb_issue got=%b want=%b", rs_busy[0], 1'b1);
        end
        write_en = 2'b01; rd_addr[4:0] = 5'd7; rd_data[31:0] = 32'h0F0F;
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        #1;
        total++;
        if (rs_busy[0] !== 1'b1) begin
            bad++; $display("FAIL sb_set_wins got=%b want=%b", rs_busy[0], 1'b1);
        end
        write_en = 2'b01;
        tick();
        idle();
        #1;
        total++;
        if (rs_busy[0] !== 1'b0) begin
            bad++; $display("FAIL sb_clear got=%b want=%b", rs_busy[0], 1'b0);
        end
        total++;
        if (rs_data[31:0] !== 32'h0F0F) begin
            bad++; $display("FAIL sb_data got=%h want=%h", rs_data[31:0], 32'h0F0F);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] same_cycle;
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'h0F0F;
`else
        same_cycle = 32'h0;
`endif
        rs_addr[4:0] = 5'd2;
        write_en = 2'b01; rd_addr[4:0] = 5'd2; rd_data[31:0] = 32'h0F0F;
        #1;
        total++;
        if (rs_data[31:0] !== same_cycle) begin
            bad++; $display("FAIL bypass_same got=%h want=%h", rs_data[31:0], same_cycle);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0F0F) begin
            bad++; $display("FAIL bypass_after got=%h want=%h", rs_data[31:0], 32'h0F0F);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0F0F) begin
            bad++; $display("FAIL reset_cycle got=%h want=%h", rs_data[31:0], 32'h0F0F);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (rs_data[31:0] !== 32'h0) begin
            bad++; $display("FAIL reset_mid got=%h want=%h", rs_data[31:0], 32'h0);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ed;
        logic            eb;
        for (int n = 0; n < 400; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            write_en   = 2'($urandom_range(0, 3));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rd_data    = {$urandom(), $urandom()};
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            rs_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            for (int i = 0; i < NRD; i++) begin
                ed = exp_data(i);
                eb = exp_busy(i);
                total++;
                if (rs_data[i*XLEN +: XLEN] !== ed) begin
                    bad++;
                    $display("FAIL rand_data n=%0d port=%0d addr=%0d got=%h want=%h",
                             n, i, rs_addr[i*AW +: AW], rs_data[i*XLEN +: XLEN], ed);
                end
                total++;
                if (rs_busy[i] !== eb) begin
                    bad++;
                    $display("FAIL rand_busy n=%0d port=%0d addr=%0d got=%b want=%b",
                             n, i, rs_addr[i*AW +: AW], rs_busy[i], eb);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n      = 1'b0;
        rs_addr    = '0;
        rd_addr    = '0;
        rd_data    = '0;
        write_en   = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        test_reset();
        test_basic();
        test_zero();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
